// File: rtl/mlu_nibble_seq.sv
// rtl/mlu_nibble_seq.sv - WIDTH-bit MLU operation run one nibble per cycle through a shared 4-bit mlu_slice.
module mlu_nibble_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             N_RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [2:0]       REQ_OP,
  input  logic [WIDTH-1:0] REQ_A,
  input  logic [WIDTH-1:0] REQ_B,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic [WIDTH-1:0] RESP_OUT,
  output logic             RESP_ZERO,
  output logic             RESP_CARRY,
  output logic [11:0]      SLICE_ADDR,
  input  logic [7:0]       SLICE_OUT
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [2:0] MLU_ADD = 3'd1;
  localparam logic [2:0] MLU_SUB = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             zero_acc;

  logic             accept;
  logic             last;
  logic [IW+1:0]    base;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic             carry_next;
  logic             zero_next;
  logic             arith_op;
  logic             slice_unused;

  assign accept       = REQ_VALID && (state == IDLE);
  assign last         = (idx == IW'(NIBBLES - 1));
  assign base         = {idx, 2'b00};
  assign a_nib        = a_q[base +: 4];
  assign b_nib        = b_q[base +: 4];
  assign carry_next   = SLICE_OUT[5] | (SLICE_OUT[4] & carry);
  assign zero_next    = zero_acc & SLICE_OUT[6];
  assign arith_op     = (op_q == MLU_ADD) || (op_q == MLU_SUB);
  assign slice_unused = SLICE_OUT[7];

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    REQ_READY  = 1'b0;
    RESP_VALID = 1'b0;
    SLICE_ADDR = 12'd0;
    case (state)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          state_next = RUN;
        end
      end
      RUN: begin
        SLICE_ADDR = {carry, op_q, b_nib, a_nib};
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        RESP_VALID = 1'b1;
        if (RESP_READY) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result nibbles land directly in RESP_OUT; RESP_VALID only rises once every nibble is written.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 3'd0;
      idx        <= '0;
      carry      <= 1'b0;
      zero_acc   <= 1'b1;
      RESP_OUT   <= '0;
      RESP_ZERO  <= 1'b0;
      RESP_CARRY <= 1'b0;
    end else if (accept) begin
      a_q      <= REQ_A;
      b_q      <= REQ_B;
      op_q     <= REQ_OP;
      idx      <= '0;
      carry    <= (REQ_OP == MLU_SUB);
      zero_acc <= 1'b1;
    end else if (state == RUN) begin
      RESP_OUT[base +: 4] <= SLICE_OUT[3:0];
      carry               <= carry_next;
      zero_acc            <= zero_next;
      if (last) begin
        idx        <= '0;
        RESP_ZERO  <= zero_next;
        RESP_CARRY <= arith_op & carry_next;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mlu_nibble_seq.sv
// tb/tb_mlu_nibble_seq.sv - directed self-checking bench for mlu_nibble_seq with a behavioural slice.
module tb_mlu_nibble_seq;

  localparam logic [2:0] MLU_NOP0 = 3'd0;
  localparam logic [2:0] MLU_ADD  = 3'd1;
  localparam logic [2:0] MLU_SUB  = 3'd2;
  localparam logic [2:0] MLU_AND  = 3'd3;
  localparam logic [2:0] MLU_OR   = 3'd4;
  localparam logic [2:0] MLU_XOR  = 3'd5;
  localparam logic [2:0] MLU_NOT  = 3'd6;
  localparam logic [2:0] MLU_NOP1 = 3'd7;

  logic        CLK = 1'b0;
  logic        N_RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [2:0]  REQ_OP;
  logic [31:0] REQ_A;
  logic [31:0] REQ_B;
  logic        RESP_VALID;
  logic        RESP_READY;
  logic [31:0] RESP_OUT;
  logic        RESP_ZERO;
  logic        RESP_CARRY;
  logic [11:0] SLICE_ADDR;
  logic [7:0]  SLICE_OUT;

  int errors = 0;
  int checks = 0;

  mlu_nibble_seq #(.WIDTH(32)) dut (
    .CLK        (CLK),
    .N_RST      (N_RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_OP     (REQ_OP),
    .REQ_A      (REQ_A),
    .REQ_B      (REQ_B),
    .RESP_VALID (RESP_VALID),
    .RESP_READY (RESP_READY),
    .RESP_OUT   (RESP_OUT),
    .RESP_ZERO  (RESP_ZERO),
    .RESP_CARRY (RESP_CARRY),
    .SLICE_ADDR (SLICE_ADDR),
    .SLICE_OUT  (SLICE_OUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural 4-bit slice: prop/gen only for ADD/SUB, SUB adds the inverted B nibble.
  logic [3:0] sa, sb, sr;
  logic [4:0] sg, ss;
  logic       sp, sgen;
  always_comb begin
    sa   = SLICE_ADDR[3:0];
    sb   = SLICE_ADDR[7:4];
    sr   = 4'h0;
    sg   = 5'd0;
    ss   = 5'd0;
    sp   = 1'b0;
    sgen = 1'b0;
    case (SLICE_ADDR[10:8])
      MLU_ADD, MLU_SUB: begin
        if (SLICE_ADDR[10:8] == MLU_SUB) sb = ~sb;
        sg   = {1'b0, sa} + {1'b0, sb};
        ss   = sg + {4'd0, SLICE_ADDR[11]};
        sr   = ss[3:0];
        sp   = ((sa ^ sb) == 4'hF);
        sgen = sg[4];
      end
      MLU_AND: sr = sa & sb;
      MLU_OR:  sr = sa | sb;
      MLU_XOR: sr = sa ^ sb;
      MLU_NOT: sr = ~sa;
      default: sr = 4'h0;
    endcase
    SLICE_OUT = {1'b0, (sr == 4'h0), sgen, sp, sr};
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] out, output logic z, output logic c, output int lat);
    @(negedge CLK);
    REQ_OP    = op;
    REQ_A     = a;
    REQ_B     = b;
    REQ_VALID = 1'b1;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    lat = 0;
    while (!RESP_VALID && lat < 20) begin
      @(posedge CLK);
      lat++;
      #1;
    end
    out = RESP_OUT;
    z   = RESP_ZERO;
    c   = RESP_CARRY;
    RESP_READY = 1'b1;
    @(posedge CLK);
    #1;
    RESP_READY = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({REQ_READY, RESP_VALID, RESP_ZERO, RESP_CARRY} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got rdy/vld/z/c=%b required 1000", {REQ_READY, RESP_VALID, RESP_ZERO, RESP_CARRY});
    end
    checks++;
    if (RESP_OUT !== 32'd0 || SLICE_ADDR !== 12'd0) begin
      errors++;
      $display("FAIL reset_data got out=%h addr=%h required 0/0", RESP_OUT, SLICE_ADDR);
    end
  endtask

  task automatic test_add();
    logic [31:0] o; logic z, c; int lat;
    do_op(MLU_ADD, 32'hFFFFFFFF, 32'h00000001, o, z, c, lat);
    checks++;
    if ({o, z, c} !== {32'h0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_wrap got out=%h z=%b c=%b required 00000000 1 1", o, z, c);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL add_latency got %0d required 8", lat);
    end
    do_op(MLU_ADD, 32'h0000000F, 32'h00000001, o, z, c, lat);
    checks++;
    if ({o, z, c} !== {32'h00000010, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_ripple got out=%h z=%b c=%b required 00000010 0 0", o, z, c);
    end
    do_op(MLU_ADD, 32'h7FFFFFFF, 32'h00000001, o, z, c, lat);
    checks++;
    if ({o, z, c} !== {32'h80000000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_msb got out=%h z=%b c=%b required 80000000 0 0", o, z, c);
    end
  endtask

  task automatic test_sub();
    logic [31:0] o; logic z, c; int lat;
    do_op(MLU_SUB, 32'h00000007, 32'h00000005, o, z, c, lat);
    checks++;
    if ({o, z, c} !== {32'h00000002, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_pos got out=%h z=%b c=%b required 00000002 0 1", o, z, c);
    end
    do_op(MLU_SUB, 32'h00000005, 32'h00000007, o, z, c, lat);
    checks++;
    if ({o, z, c} !== {32'hFFFFFFFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_neg got out=%h z=%b c=%b required fffffffe 0 0", o, z, c);
    end
    do_op(MLU_SUB, 32'h00001234, 32'h00001234, o, z, c, lat);
    checks++;
    if ({o, z, c} !== {32'h0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_equal got out=%h z=%b c=%b required 00000000 1 1", o, z, c);
    end
  endtask

  task automatic test_logic();
    logic [31:0] o; logic z, c; int lat;
    do_op(MLU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, o, z, c, lat);
    checks++;
    if ({o, z, c} !== {32'h00F000F0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL and got out=%h z=%b c=%b required 00f000f0 0 0", o, z, c);
    end
    do_op(MLU_XOR, 32'hA5A5A5A5, 32'hFFFF0000, o, z, c, lat);
    checks++;
    if ({o, z, c} !== {32'h5A5AA5A5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL xor got out=%h z=%b c=%b required 5a5aa5a5 0 0", o, z, c);
    end
    do_op(MLU_NOT, 32'hFFFFFFFF, 32'h12345678, o, z, c, lat);
    checks++;
    if ({o, z, c} !== {32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL not got out=%h z=%b c=%b required 00000000 1 0", o, z, c);
    end
    do_op(MLU_NOP1, 32'hFFFFFFFF, 32'hFFFFFFFF, o, z, c, lat);
    checks++;
    if ({o, z, c} !== {32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL nop1 got out=%h z=%b c=%b required 00000000 1 0", o, z, c);
    end
  endtask

  task automatic test_slice_addr();
    int n;
    @(negedge CLK);
    REQ_OP = MLU_SUB; REQ_A = 32'h00000007; REQ_B = 32'h00000005; REQ_VALID = 1'b1;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    checks++;
    if (SLICE_ADDR !== 12'hA57) begin
      errors++;
      $display("FAIL addr_nib0 got %h required a57", SLICE_ADDR);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (SLICE_ADDR !== 12'hA00) begin
      errors++;
      $display("FAIL addr_nib1 got %h required a00", SLICE_ADDR);
    end
    n = 0;
    while (!RESP_VALID && n < 20) begin
      @(posedge CLK);
      n++;
      #1;
    end
    RESP_READY = 1'b1;
    @(posedge CLK);
    #1;
    RESP_READY = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] o; logic z, c; int n;
    @(negedge CLK);
    REQ_OP = MLU_ADD; REQ_A = 32'd3; REQ_B = 32'd4; REQ_VALID = 1'b1;
    @(posedge CLK);
    #1;
    REQ_A = 32'd10; REQ_B = 32'd20;
    n = 0;
    while (!RESP_VALID && n < 20) begin
      @(posedge CLK);
      n++;
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({RESP_VALID, REQ_READY, RESP_OUT} !== {1'b1, 1'b0, 32'd7}) begin
        errors++;
        $display("FAIL bp_hold_%0d got vld=%b rdy=%b out=%h required 1 0 00000007", i, RESP_VALID, REQ_READY, RESP_OUT);
      end
      @(posedge CLK);
      #1;
    end
    RESP_READY = 1'b1;
    @(posedge CLK);
    #1;
    RESP_READY = 1'b0;
    checks++;
    if ({RESP_VALID, REQ_READY} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b required 0 1", RESP_VALID, REQ_READY);
    end
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    checks++;
    if (REQ_READY !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got rdy=%b required 0", REQ_READY);
    end
    n = 0;
    while (!RESP_VALID && n < 20) begin
      @(posedge CLK);
      n++;
      #1;
    end
    o = RESP_OUT; z = RESP_ZERO; c = RESP_CARRY;
    checks++;
    if ({o, z, c, n} !== {32'd30, 1'b0, 1'b0, 32'd8}) begin
      errors++;
      $display("FAIL bp_second got out=%h z=%b c=%b lat=%0d required 0000001e 0 0 8", o, z, c, n);
    end
    RESP_READY = 1'b1;
    @(posedge CLK);
    #1;
    RESP_READY = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] o; logic z, c; int lat; logic seen;
    @(negedge CLK);
    REQ_OP = MLU_ADD; REQ_A = 32'h11111111; REQ_B = 32'h22222222; REQ_VALID = 1'b1;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    N_RST = 1'b0;
    #1;
    checks++;
    if ({RESP_VALID, REQ_READY, SLICE_ADDR, RESP_OUT} !== {1'b0, 1'b1, 12'd0, 32'd0}) begin
      errors++;
      $display("FAIL areset got vld=%b rdy=%b addr=%h out=%h required 0 1 000 00000000", RESP_VALID, REQ_READY, SLICE_ADDR, RESP_OUT);
    end
    @(negedge CLK);
    @(negedge CLK);
    N_RST = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge CLK);
      #1;
      if (RESP_VALID) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL areset_no_resp got resp_valid seen=%b required 0", seen);
    end
    do_op(MLU_ADD, 32'd1, 32'd2, o, z, c, lat);
    checks++;
    if ({o, z, c, lat} !== {32'd3, 1'b0, 1'b0, 32'd8}) begin
      errors++;
      $display("FAIL areset_recover got out=%h z=%b c=%b lat=%0d required 00000003 0 0 8", o, z, c, lat);
    end
  endtask

  initial begin
    N_RST = 1'b0;
    REQ_VALID = 1'b0;
    REQ_OP = MLU_NOP0;
    REQ_A = 32'd0;
    REQ_B = 32'd0;
    RESP_READY = 1'b0;
    repeat (3) @(negedge CLK);
    test_reset();
    N_RST = 1'b1;
    test_add();
    test_sub();
    test_logic();
    test_slice_addr();
    test_backpressure();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
